// File: rtl/trap_pkg.sv
// Shared types and constants for the trap/return sequencer.
package trap_pkg;

    // Trap cause codes as reported on the cause port
    typedef enum logic [1:0] {
        C_NONE = 2'd0,
        C_SYS  = 2'd1,
        C_ILL  = 2'd2,
        C_IRQ  = 2'd3
    } cause_t;

    // Sequencer states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SAVE   = 2'd1,
        VECTOR = 2'd2,
        RET    = 2'd3
    } trap_state_t;

    localparam logic MODE_USER = 1'b0;
    localparam logic MODE_KERN = 1'b1;

    // Clear mask applied to every status flag on trap entry
    localparam logic [3:0] FLAGS_ALL = 4'hF;

endpackage

// File: rtl/trap_prio_enc.sv
// Fixed-priority event encoder: illegal > eret > syscall > irq.
// ERET from user mode is privileged and becomes an illegal-instruction trap;
// irq is only accepted in user mode with interrupts enabled.
module trap_prio_enc
    import trap_pkg::*;
(
    input  logic   sample,
    input  logic   illegal_req,
    input  logic   eret_req,
    input  logic   syscall_req,
    input  logic   irq,
    input  logic   mode,
    input  logic   ie,
    output logic   take_trap,
    output logic   take_eret,
    output cause_t code
);

    // Resolve the highest-priority event at an instruction boundary
    always_comb begin
        take_trap = 1'b0;
        take_eret = 1'b0;
        code      = C_NONE;
        if (sample) begin
            if (illegal_req) begin
                take_trap = 1'b1;
                code      = C_ILL;
            end else if (eret_req) begin
                if (mode == MODE_KERN) begin
                    take_eret = 1'b1;
                end else begin
                    take_trap = 1'b1;
                    code      = C_ILL;
                end
            end else if (syscall_req) begin
                take_trap = 1'b1;
                code      = C_SYS;
            end else if (irq && ie && (mode == MODE_USER)) begin
                take_trap = 1'b1;
                code      = C_IRQ;
            end
        end
    end

endmodule

// File: rtl/trap_mode_ctrl.sv
// Trap/return sequencer owning the user/kernel mode bit. Saves return state on
// a trap, clears flags, enters kernel mode and vectors; ERET restores flags and
// mode and returns to the saved PC. Strobes are Moore outputs of the state.
module trap_mode_ctrl
    import trap_pkg::*;
#(
    parameter logic [31:0] VEC_ADDR   = 32'h0000_0080,
    parameter logic        RESET_MODE = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        instr_done,
    input  logic [31:0] pc_next,
    input  logic        syscall_req,
    input  logic        illegal_req,
    input  logic        eret_req,
    input  logic        irq,
    input  logic [31:0] status_in,
    output logic        mode,
    output logic [3:0]  clr_flag,
    output logic        flag_ovr_en,
    output logic [3:0]  flag_ovr_val,
    output logic        pc_redirect,
    output logic [31:0] pc_target,
    output logic [31:0] epc,
    output logic [1:0]  cause,
    output logic        stall
);

    trap_state_t state_reg;
    logic        mode_reg;
    logic        ie_reg;
    logic [31:0] epc_reg;
    cause_t      cause_reg;
    cause_t      pend_cause_reg;
    logic [3:0]  saved_flags_reg;
    logic        saved_mode_reg;

    logic        take_trap;
    logic        take_eret;
    cause_t      code;

    // Only the flag nibble of the status word is snapshotted
    logic        unused_status;
    assign unused_status = ^status_in[27:0];

    trap_prio_enc u_prio (
        .sample      (instr_done && (state_reg == IDLE)),
        .illegal_req (illegal_req),
        .eret_req    (eret_req),
        .syscall_req (syscall_req),
        .irq         (irq),
        .mode        (mode_reg),
        .ie          (ie_reg),
        .take_trap   (take_trap),
        .take_eret   (take_eret),
        .code        (code)
    );

    // Sequencer state and architectural trap state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= IDLE;
            mode_reg        <= RESET_MODE;
            ie_reg          <= 1'b1;
            epc_reg         <= 32'h0;
            cause_reg       <= C_NONE;
            pend_cause_reg  <= C_NONE;
            saved_flags_reg <= 4'h0;
            saved_mode_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (take_trap) begin
                        // Hold the cause until SAVE commits it
                        pend_cause_reg <= code;
                        state_reg      <= SAVE;
                    end else if (take_eret) begin
                        state_reg <= RET;
                    end
                end
                SAVE: begin
                    epc_reg         <= pc_next;
                    cause_reg       <= pend_cause_reg;
                    saved_flags_reg <= status_in[31:28];
                    saved_mode_reg  <= mode_reg;
                    mode_reg        <= MODE_KERN;
                    ie_reg          <= 1'b0;
                    state_reg       <= VECTOR;
                end
                VECTOR: begin
                    state_reg <= IDLE;
                end
                RET: begin
                    mode_reg  <= saved_mode_reg;
                    ie_reg    <= 1'b1;
                    cause_reg <= C_NONE;
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // Moore strobe decode from the current state
    always_comb begin
        clr_flag     = 4'h0;
        flag_ovr_en  = 1'b0;
        flag_ovr_val = 4'h0;
        pc_redirect  = 1'b0;
        pc_target    = 32'h0;
        stall        = 1'b0;
        case (state_reg)
            SAVE: begin
                clr_flag = FLAGS_ALL;
                stall    = 1'b1;
            end
            VECTOR: begin
                pc_redirect = 1'b1;
                pc_target   = VEC_ADDR;
                stall       = 1'b1;
            end
            RET: begin
                flag_ovr_en  = 1'b1;
                flag_ovr_val = saved_flags_reg;
                pc_redirect  = 1'b1;
                pc_target    = epc_reg;
                stall        = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign mode  = mode_reg;
    assign epc   = epc_reg;
    assign cause = cause_reg;

endmodule

// File: tb/tb_trap_mode_ctrl.sv
// Directed bench for trap_mode_ctrl: trap entry, ERET, priority, irq gating,
// privileged ERET and reset in the middle of a sequence.
module tb_trap_mode_ctrl;

    logic        clk;
    logic        rst_n;
    logic        instr_done;
    logic [31:0] pc_next;
    logic        syscall_req;
    logic        illegal_req;
    logic        eret_req;
    logic        irq;
    logic [31:0] status_in;
    logic        mode;
    logic [3:0]  clr_flag;
    logic        flag_ovr_en;
    logic [3:0]  flag_ovr_val;
    logic        pc_redirect;
    logic [31:0] pc_target;
    logic [31:0] epc;
    logic [1:0]  cause;
    logic        stall;

    int checks = 0;
    int errors = 0;

    trap_mode_ctrl #(
        .VEC_ADDR   (32'h0000_0080),
        .RESET_MODE (1'b1)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .instr_done   (instr_done),
        .pc_next      (pc_next),
        .syscall_req  (syscall_req),
        .illegal_req  (illegal_req),
        .eret_req     (eret_req),
        .irq          (irq),
        .status_in    (status_in),
        .mode         (mode),
        .clr_flag     (clr_flag),
        .flag_ovr_en  (flag_ovr_en),
        .flag_ovr_val (flag_ovr_val),
        .pc_redirect  (pc_redirect),
        .pc_target    (pc_target),
        .epc          (epc),
        .cause        (cause),
        .stall        (stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are observed 1 time unit after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_reqs();
        instr_done  = 1'b0;
        syscall_req = 1'b0;
        illegal_req = 1'b0;
        eret_req    = 1'b0;
    endtask

    initial begin
        rst_n       = 1'b0;
        irq         = 1'b0;
        pc_next     = 32'h0;
        status_in   = 32'h0;
        clear_reqs();

        // 1. Reset state
        #12;
        chk("rst_mode", mode, 1);
        chk("rst_epc", epc, 0);
        chk("rst_cause", cause, 0);
        chk("rst_stall", stall, 0);
        chk("rst_redirect", pc_redirect, 0);
        chk("rst_target", pc_target, 0);
        $display("reset: mode=%0d epc=%h cause=%0d stall=%0d", mode, epc, cause, stall);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("idle_no_redirect", pc_redirect, 0);
        end

        // Drop to user mode: ERET from reset restores saved_mode = 0, flags 0, PC 0
        eret_req = 1'b1; instr_done = 1'b1;
        step(); clear_reqs();
        chk("boot_ret_ovr_en", flag_ovr_en, 1);
        chk("boot_ret_target", pc_target, 0);
        step();
        chk("boot_user_mode", mode, 0);
        $display("boot eret: mode=%0d", mode);

        // 2. Syscall in user mode
        status_in = 32'hA000_0000; pc_next = 32'h100;
        syscall_req = 1'b1; instr_done = 1'b1;
        step(); clear_reqs();
        chk("sys_save_clr", clr_flag, 4'hF);
        chk("sys_save_stall", stall, 1);
        chk("sys_save_noredir", pc_redirect, 0);
        step();
        chk("sys_vec_redirect", pc_redirect, 1);
        chk("sys_vec_target", pc_target, 32'h80);
        chk("sys_vec_epc", epc, 32'h100);
        chk("sys_vec_cause", cause, 1);
        chk("sys_vec_mode", mode, 1);
        chk("sys_vec_clr", clr_flag, 0);
        step();
        chk("sys_idle_redirect", pc_redirect, 0);
        chk("sys_idle_stall", stall, 0);
        $display("syscall: epc=%h cause=%0d mode=%0d", epc, cause, mode);

        // 3. ERET back to user
        eret_req = 1'b1; instr_done = 1'b1;
        step(); clear_reqs();
        chk("ret_ovr_en", flag_ovr_en, 1);
        chk("ret_ovr_val", flag_ovr_val, 4'b1010);
        chk("ret_target", pc_target, 32'h100);
        chk("ret_redirect", pc_redirect, 1);
        chk("ret_mode_still_k", mode, 1);
        step();
        chk("ret_mode_user", mode, 0);
        chk("ret_cause_clr", cause, 0);
        chk("ret_ovr_off", flag_ovr_en, 0);
        $display("eret: mode=%0d cause=%0d", mode, cause);

        // 4. illegal + syscall + irq together: illegal wins
        status_in = 32'h5000_0000; pc_next = 32'h200;
        illegal_req = 1'b1; syscall_req = 1'b1; irq = 1'b1; instr_done = 1'b1;
        step(); clear_reqs(); irq = 1'b0;
        chk("prio_save_clr", clr_flag, 4'hF);
        step();
        chk("prio_redirect", pc_redirect, 1);
        chk("prio_cause", cause, 2);
        chk("prio_epc", epc, 32'h200);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("prio_single_redirect", pc_redirect, 0);
        end
        $display("priority: cause=%0d epc=%h", cause, epc);

        // 5. irq held in kernel mode is not taken
        irq = 1'b1; instr_done = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("irq_kern_stall", stall, 0);
            chk("irq_kern_redirect", pc_redirect, 0);
        end
        // ERET outranks the pending irq and returns to user
        eret_req = 1'b1;
        step(); clear_reqs();
        chk("irq_ret_ovr_val", flag_ovr_val, 4'h5);
        chk("irq_ret_target", pc_target, 32'h200);
        step();
        chk("irq_ret_mode", mode, 0);
        pc_next = 32'h300; instr_done = 1'b1;
        step(); clear_reqs();
        chk("irq_save_stall", stall, 1);
        step();
        irq = 1'b0;
        chk("irq_redirect", pc_redirect, 1);
        chk("irq_cause", cause, 3);
        chk("irq_epc", epc, 32'h300);
        chk("irq_mode", mode, 1);
        step();
        $display("irq: cause=%0d epc=%h mode=%0d", cause, epc, mode);

        // 6a. ERET to user, then ERET from user -> illegal trap
        eret_req = 1'b1; instr_done = 1'b1;
        step(); clear_reqs();
        step();
        chk("priv_user_mode", mode, 0);
        pc_next = 32'h400; eret_req = 1'b1; instr_done = 1'b1;
        step(); clear_reqs();
        chk("priv_save_clr", clr_flag, 4'hF);
        chk("priv_no_ovr", flag_ovr_en, 0);
        step();
        chk("priv_cause", cause, 2);
        chk("priv_epc", epc, 32'h400);
        chk("priv_target", pc_target, 32'h80);
        step();
        $display("user eret: cause=%0d epc=%h", cause, epc);

        // Kernel-mode syscall: saved_mode = 1 so ERET stays in kernel
        pc_next = 32'h600; syscall_req = 1'b1; instr_done = 1'b1;
        step(); clear_reqs();
        step();
        chk("ksys_cause", cause, 1);
        chk("ksys_epc", epc, 32'h600);
        step();
        eret_req = 1'b1; instr_done = 1'b1;
        step(); clear_reqs();
        chk("ksys_ret_target", pc_target, 32'h600);
        step();
        chk("ksys_ret_mode", mode, 1);
        $display("kernel syscall: eret mode=%0d", mode);

        // 6b. Reset asserted during SAVE
        pc_next = 32'h500; syscall_req = 1'b1; instr_done = 1'b1;
        step(); clear_reqs();
        chk("rstmid_save_stall", stall, 1);
        rst_n = 1'b0;
        #1;
        chk("rstmid_stall", stall, 0);
        chk("rstmid_redirect", pc_redirect, 0);
        chk("rstmid_epc", epc, 0);
        chk("rstmid_cause", cause, 0);
        step();
        chk("rstmid_hold_redirect", pc_redirect, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rstmid_after_redirect", pc_redirect, 0);
        end
        chk("rstmid_mode", mode, 1);
        $display("reset mid-save: stall=%0d epc=%h", stall, epc);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
